// File: rtl/light_intensity_multi.sv
// Back-face cull + multi-light Lambert accumulation on one shared 3-term dot engine; culled result at T+2, lit at T+NUM_LIGHTS+3.
// Single job in flight: ready_out only in IDLE, result held on valid_out until ready_in; light writes accepted in any state.
module light_intensity_multi #(
  parameter int NORM_WIDTH  = 16,
  parameter int NORM_FRAC   = 14,
  parameter int NUM_LIGHTS  = 4,
  parameter int LIGHT_IDX_W = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic [3*NORM_WIDTH-1:0]      tri_norm_in,
  input  logic [3*NORM_WIDTH-1:0]      cam_norm_in,
  input  logic signed [NORM_WIDTH-1:0] ambient_in,
  input  logic                         valid_in,
  output logic                         ready_out,
  input  logic                         light_we_in,
  input  logic [LIGHT_IDX_W-1:0]       light_idx_in,
  input  logic [3*NORM_WIDTH-1:0]      light_dir_in,
  output logic signed [NORM_WIDTH-1:0] intensity_out,
  output logic                         culled_out,
  output logic                         valid_out,
  input  logic                         ready_in
);

  localparam int W     = NORM_WIDTH;
  localparam int DOT_W = 2 * W + 2;
  localparam int ACC_W = W + LIGHT_IDX_W + 2;
  localparam int SUM_W = ACC_W + 1;
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(1 << NORM_FRAC);
  localparam logic signed [W-1:0]     ONE_W   = W'(1 << NORM_FRAC);

  typedef enum logic [2:0] {S_IDLE, S_CULL, S_ACCUM, S_SAT, S_OUT} state_t;

  state_t                   r_state, w_next;
  logic [3*W-1:0]           r_tri, r_cam;
  logic signed [W-1:0]      r_amb;
  logic signed [ACC_W-1:0]  r_acc;
  logic [LIGHT_IDX_W-1:0]   r_idx;
  logic [3*W-1:0]           r_light [NUM_LIGHTS];
  logic signed [W-1:0]      r_intensity;
  logic                     r_culled;

  logic [3*W-1:0]           w_opb;
  logic signed [W-1:0]      w_a [3];
  logic signed [W-1:0]      w_b [3];
  logic signed [2*W-1:0]    w_p [3];
  logic signed [DOT_W-1:0]  w_sum, w_dot;
  logic signed [ACC_W-1:0]  w_contrib;
  logic signed [SUM_W-1:0]  w_sat_sum;
  logic signed [W-1:0]      w_sat;
  logic                     w_last, w_idx_ok, w_neg;

  // The dot engine compares against the camera in CULL and against light[r_idx] in ACCUM.
  always_comb begin
    w_opb = (r_state == S_CULL) ? r_cam : r_light[r_idx];
    for (int k = 0; k < 3; k++) begin
      w_a[k] = r_tri[k*W +: W];
      w_b[k] = w_opb[k*W +: W];
      w_p[k] = (2*W)'(w_a[k]) * (2*W)'(w_b[k]);
    end
    w_sum = DOT_W'(w_p[0]) + DOT_W'(w_p[1]) + DOT_W'(w_p[2]);
    w_dot = w_sum >>> NORM_FRAC;
    w_neg = w_dot[DOT_W-1];
  end

  always_comb begin
    w_contrib = w_neg ? ACC_W'(-w_dot) : '0;
    w_sat_sum = SUM_W'(r_acc) + SUM_W'(r_amb);
    if (w_sat_sum[SUM_W-1])
      w_sat = '0;
    else if (w_sat_sum > SAT_MAX)
      w_sat = ONE_W;
    else
      w_sat = W'(w_sat_sum);
    w_last   = (r_idx == LIGHT_IDX_W'(NUM_LIGHTS - 1));
    w_idx_ok = (32'(light_idx_in) < NUM_LIGHTS);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (valid_in) w_next = S_CULL;
      S_CULL:  w_next = w_neg ? S_ACCUM : S_OUT;
      S_ACCUM: if (w_last) w_next = S_SAT;
      S_SAT:   w_next = S_OUT;
      S_OUT:   if (ready_in) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_tri       <= '0;
      r_cam       <= '0;
      r_amb       <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_intensity <= '0;
      r_culled    <= 1'b0;
      for (int k = 0; k < NUM_LIGHTS; k++) r_light[k] <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (valid_in) begin
          r_tri <= tri_norm_in;
          r_cam <= cam_norm_in;
          r_amb <= ambient_in;
          r_acc <= '0;
          r_idx <= '0;
        end
        // A zero facing term counts as back-facing.
        S_CULL: if (!w_neg) begin
          r_culled    <= 1'b1;
          r_intensity <= '0;
        end
        S_ACCUM: begin
          r_acc <= r_acc + w_contrib;
          r_idx <= r_idx + LIGHT_IDX_W'(1);
        end
        S_SAT: begin
          r_intensity <= w_sat;
          r_culled    <= 1'b0;
        end
        default: ;
      endcase
      if (light_we_in && w_idx_ok) r_light[light_idx_in] <= light_dir_in;
    end
  end

  assign ready_out     = (r_state == S_IDLE);
  assign valid_out     = (r_state == S_OUT);
  assign intensity_out = r_intensity;
  assign culled_out    = r_culled;

endmodule
